// File: rtl/fft_twiddle_apply.sv
// Complex multiply of a sample stream by generator twiddles, 3-stage valid/ready pipeline
// with round-half-up and saturation; bypassed samples pass bit-exact without consuming a twiddle.
module fft_twiddle_apply #(
    parameter int SET        = 3,
    parameter int DATA_WIDTH = 16,
    parameter int TW_WIDTH   = 16,
    parameter int TW_FRAC    = 14
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         in_bypass,
    input  logic signed [DATA_WIDTH-1:0] in_r,
    input  logic signed [DATA_WIDTH-1:0] in_i,
    input  logic signed [TW_WIDTH-1:0]   tw_r,
    input  logic signed [TW_WIDTH-1:0]   tw_i,
    output logic                         tw_pop,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [DATA_WIDTH-1:0] out_r,
    output logic signed [DATA_WIDTH-1:0] out_i,
    output logic                         out_tw_last
);

    localparam int CW = (SET > 1) ? SET - 1 : 1;
    localparam logic [CW-1:0] TW_LAST = CW'((2 ** (SET - 1)) - 1);
    localparam int PW = DATA_WIDTH + TW_WIDTH;
    localparam int SW = PW + 2;
    localparam logic signed [SW-1:0] RND_HALF = SW'(2 ** (TW_FRAC - 1));
    localparam logic signed [SW-1:0] SAT_MAX  = {{(SW - DATA_WIDTH + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
    localparam logic signed [SW-1:0] SAT_MIN  = ~SAT_MAX;

    logic adv;
    logic accept;

    logic [CW-1:0] tw_cnt_reg;

    logic                         s1_valid_reg;
    logic                         s1_bypass_reg;
    logic                         s1_last_reg;
    logic signed [DATA_WIDTH-1:0] s1_r_reg;
    logic signed [DATA_WIDTH-1:0] s1_i_reg;
    logic signed [TW_WIDTH-1:0]   s1_tw_r_reg;
    logic signed [TW_WIDTH-1:0]   s1_tw_i_reg;

    logic                         s2_valid_reg;
    logic                         s2_bypass_reg;
    logic                         s2_last_reg;
    logic signed [DATA_WIDTH-1:0] s2_d_reg [2];
    logic signed [PW-1:0]         s2_rr_reg;
    logic signed [PW-1:0]         s2_ii_reg;
    logic signed [PW-1:0]         s2_ri_reg;
    logic signed [PW-1:0]         s2_ir_reg;

    logic                         s3_valid_reg;
    logic                         out_last_reg;
    logic signed [DATA_WIDTH-1:0] out_d_reg  [2];
    logic signed [DATA_WIDTH-1:0] out_d_next [2];
    logic signed [SW-1:0]         sum_w      [2];
    logic signed [DATA_WIDTH-1:0] sat_val    [2];

    // Whole pipeline moves together; only a full, stalled output stage blocks it.
    assign adv      = !s3_valid_reg || out_ready;
    assign in_ready = adv && !rst;
    assign accept   = in_valid && in_ready;
    assign tw_pop   = accept && !in_bypass;

    always_ff @(posedge clk) begin
        if (rst) begin
            tw_cnt_reg <= '0;
        end else if (tw_pop) begin
            tw_cnt_reg <= (tw_cnt_reg == TW_LAST) ? '0 : tw_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_reg  <= 1'b0;
            s1_bypass_reg <= 1'b0;
            s1_last_reg   <= 1'b0;
            s1_r_reg      <= '0;
            s1_i_reg      <= '0;
            s1_tw_r_reg   <= '0;
            s1_tw_i_reg   <= '0;
        end else if (adv) begin
            s1_valid_reg  <= accept;
            s1_bypass_reg <= in_bypass;
            s1_last_reg   <= (tw_cnt_reg == TW_LAST) && !in_bypass;
            s1_r_reg      <= in_r;
            s1_i_reg      <= in_i;
            s1_tw_r_reg   <= tw_r;
            s1_tw_i_reg   <= tw_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_reg  <= 1'b0;
            s2_bypass_reg <= 1'b0;
            s2_last_reg   <= 1'b0;
            s2_d_reg[0]   <= '0;
            s2_d_reg[1]   <= '0;
            s2_rr_reg     <= '0;
            s2_ii_reg     <= '0;
            s2_ri_reg     <= '0;
            s2_ir_reg     <= '0;
        end else if (adv) begin
            s2_valid_reg  <= s1_valid_reg;
            s2_bypass_reg <= s1_bypass_reg;
            s2_last_reg   <= s1_last_reg;
            s2_d_reg[0]   <= s1_r_reg;
            s2_d_reg[1]   <= s1_i_reg;
            s2_rr_reg     <= PW'(s1_r_reg) * PW'(s1_tw_r_reg);
            s2_ii_reg     <= PW'(s1_i_reg) * PW'(s1_tw_i_reg);
            s2_ri_reg     <= PW'(s1_r_reg) * PW'(s1_tw_i_reg);
            s2_ir_reg     <= PW'(s1_i_reg) * PW'(s1_tw_r_reg);
        end
    end

    assign sum_w[0] = SW'(s2_rr_reg) - SW'(s2_ii_reg);
    assign sum_w[1] = SW'(s2_ri_reg) + SW'(s2_ir_reg);

    // Component 0 is the real part, 1 the imaginary part.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_comp
            logic signed [SW-1:0] rnd;
            assign rnd = (sum_w[gi] + RND_HALF) >>> TW_FRAC;
            assign sat_val[gi] = (rnd > SAT_MAX) ? SAT_MAX[DATA_WIDTH-1:0] :
                                 (rnd < SAT_MIN) ? SAT_MIN[DATA_WIDTH-1:0] :
                                                   rnd[DATA_WIDTH-1:0];
            assign out_d_next[gi] = s2_bypass_reg ? s2_d_reg[gi] : sat_val[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            s3_valid_reg <= 1'b0;
            out_last_reg <= 1'b0;
            out_d_reg[0] <= '0;
            out_d_reg[1] <= '0;
        end else if (adv) begin
            s3_valid_reg <= s2_valid_reg;
            out_last_reg <= s2_last_reg;
            out_d_reg[0] <= out_d_next[0];
            out_d_reg[1] <= out_d_next[1];
        end
    end

    assign out_valid   = s3_valid_reg;
    assign out_r       = out_d_reg[0];
    assign out_i       = out_d_reg[1];
    assign out_tw_last = out_last_reg;

endmodule

// File: tb/tb_fft_twiddle_apply.sv
// Self-checking bench for fft_twiddle_apply: directed vector table, hand-written latency,
// reset, stream, bypass and backpressure sequences, then randomized traffic against a scoreboard.
module tb_fft_twiddle_apply;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic               in_bypass;
    logic signed [15:0] in_r;
    logic signed [15:0] in_i;
    logic signed [15:0] tw_r;
    logic signed [15:0] tw_i;
    logic               tw_pop;
    logic               out_valid;
    logic               out_ready;
    logic signed [15:0] out_r;
    logic signed [15:0] out_i;
    logic               out_tw_last;

    fft_twiddle_apply #(.SET(3), .DATA_WIDTH(16), .TW_WIDTH(16), .TW_FRAC(14)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_bypass(in_bypass),
        .in_r(in_r), .in_i(in_i), .tw_r(tw_r), .tw_i(tw_i), .tw_pop(tw_pop),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_r(out_r), .out_i(out_i), .out_tw_last(out_tw_last)
    );

    typedef struct {
        logic signed [15:0] r, i, twr, twi;
        logic               byp;
        logic signed [15:0] er, ei;
    } vec_t;

    typedef struct {
        logic signed [15:0] r, i;
        logic               last;
    } exp_t;

    int   n_vec = 0;
    int   n_err = 0;
    exp_t exp_q[$];
    vec_t tbl[10];

    // Twiddle source: either an FFT_twiddle_8 model (W8^0..W8^3) or values driven directly.
    logic               gen_mode = 1'b0;
    logic               use_tbl = 1'b0;
    logic signed [15:0] drv_tw_r = '0, drv_tw_i = '0;
    logic signed [15:0] tbl_er = '0, tbl_ei = '0;
    logic signed [15:0] tab_r[4], tab_i[4];
    logic [1:0]         gen_ptr;
    int                 model_cnt = 0;
    int                 pop_cnt = 0;
    int                 pc0;
    logic               took;

    assign tw_r = gen_mode ? tab_r[gen_ptr] : drv_tw_r;
    assign tw_i = gen_mode ? tab_i[gen_ptr] : drv_tw_i;

    always @(posedge clk) begin
        if (rst) gen_ptr <= 2'd0;
        else if (tw_pop) gen_ptr <= gen_ptr + 2'd1;
    end

    task automatic chk(input string name, input longint act, input longint req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, req, $time);
        end
    endtask

    function automatic logic signed [15:0] rnd_sat(input longint v);
        longint q;
        q = (v + 64'sd8192) >>> 14;
        if (q > 32767) return 16'sh7fff;
        if (q < -32768) return 16'sh8000;
        return 16'(q);
    endfunction

    function automatic vec_t mk(input int r, input int i, input int twr, input int twi,
                                input int byp, input int er, input int ei);
        vec_t v;
        v.r = 16'(r); v.i = 16'(i); v.twr = 16'(twr); v.twi = 16'(twi);
        v.byp = (byp != 0); v.er = 16'(er); v.ei = 16'(ei);
        return v;
    endfunction

    function automatic logic signed [15:0] rdat();
        case ($urandom % 8)
            0: return 16'sh7fff;
            1: return 16'sh8000;
            default: return 16'($urandom);
        endcase
    endfunction

    // Scoreboard / reference model: sampled on the falling edge, away from the active edge.
    exp_t               mon_e;
    longint             mon_re, mon_im;
    logic signed [15:0] mon_twr, mon_twi;
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            model_cnt = 0;
        end else begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out_valid", 1, 0);
                end else begin
                    chk("out_r", out_r, exp_q[0].r);
                    chk("out_i", out_i, exp_q[0].i);
                    chk("out_tw_last", out_tw_last, exp_q[0].last);
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
            if (tw_pop) pop_cnt++;
            if (in_valid && in_ready) begin
                chk("tw_pop_on_accept", tw_pop, !in_bypass);
                if (in_bypass) begin
                    mon_e.r = in_r; mon_e.i = in_i; mon_e.last = 1'b0;
                end else begin
                    mon_twr = gen_mode ? tab_r[model_cnt] : drv_tw_r;
                    mon_twi = gen_mode ? tab_i[model_cnt] : drv_tw_i;
                    mon_re = longint'(in_r) * longint'(mon_twr) - longint'(in_i) * longint'(mon_twi);
                    mon_im = longint'(in_r) * longint'(mon_twi) + longint'(in_i) * longint'(mon_twr);
                    mon_e.r = rnd_sat(mon_re);
                    mon_e.i = rnd_sat(mon_im);
                    mon_e.last = (model_cnt == 3);
                    model_cnt = (model_cnt + 1) % 4;
                end
                if (use_tbl) begin
                    mon_e.r = tbl_er; mon_e.i = tbl_ei;
                end
                exp_q.push_back(mon_e);
            end else begin
                chk("tw_pop_idle", tw_pop, 0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a sample and hold it until accepted; returns one cycle after the accepting edge.
    task automatic send(input logic signed [15:0] r, input logic signed [15:0] i, input logic byp);
        in_valid = 1'b1; in_r = r; in_i = i; in_bypass = byp;
        for (int w = 0; w < 100; w++) begin
            #1;
            if (in_ready) begin
                @(posedge clk);
                #1;
                return;
            end
            @(posedge clk);
            #1;
        end
        n_vec++;
        n_err++;
        $display("FAIL send_timeout: in_ready stuck at 0, expected 1 within 100 cycles");
        in_valid = 1'b0;
    endtask

    task automatic rand_phase(input int cycles);
        took = 1'b0;
        for (int k = 0; k < cycles; k++) begin
            out_ready = ($urandom % 4) != 0;
            if (!in_valid || took) begin
                in_valid  = ($urandom % 5) != 0;
                in_r      = rdat();
                in_i      = rdat();
                in_bypass = ($urandom % 4) == 0;
                if (!gen_mode) begin
                    drv_tw_r = rdat();
                    drv_tw_i = rdat();
                end
            end
            #1;
            took = in_valid && in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (8) step();
        chk("rand_drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        tab_r[0] = 16'sd16384;  tab_i[0] = 16'sd0;
        tab_r[1] = 16'sd11585;  tab_i[1] = -16'sd11585;
        tab_r[2] = 16'sd0;      tab_i[2] = -16'sd16384;
        tab_r[3] = -16'sd11585; tab_i[3] = -16'sd11585;

        tbl[0] = mk(1234, -567, 16384, 0, 0, 1234, -567);
        tbl[1] = mk(1000, 0, 11585, -11585, 0, 707, -707);
        tbl[2] = mk(100, 200, 0, -16384, 0, 200, -100);
        tbl[3] = mk(32767, 32767, 11585, -11585, 0, 32767, 0);
        tbl[4] = mk(-32768, 0, 16384, 0, 0, -32768, 0);
        tbl[5] = mk(-5, 32767, 123, 456, 1, -5, 32767);
        tbl[6] = mk(1, 0, 8192, 0, 0, 1, 0);
        tbl[7] = mk(-1, 0, 8192, 0, 0, 0, 0);
        tbl[8] = mk(-32768, -32768, 11585, 11585, 0, 0, -32768);
        tbl[9] = mk(-32768, 0, -16384, 0, 0, 32767, 0);

        rst = 1'b1; in_valid = 1'b0; in_bypass = 1'b0; in_r = '0; in_i = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_r", out_r, 0);
        chk("reset_out_i", out_i, 0);
        chk("reset_out_tw_last", out_tw_last, 0);
        chk("reset_in_ready", in_ready, 0);
        rst = 1'b0;
        step();

        // Directed table with explicit twiddles; last flag comes from the running pop count.
        use_tbl = 1'b1;
        for (int k = 0; k < 10; k++) begin
            drv_tw_r = tbl[k].twr; drv_tw_i = tbl[k].twi;
            tbl_er = tbl[k].er; tbl_ei = tbl[k].ei;
            send(tbl[k].r, tbl[k].i, tbl[k].byp);
            in_valid = 1'b0;
            repeat (4) step();
        end
        use_tbl = 1'b0;

        // Latency: accept at cycle N gives out_valid at N+3.
        drv_tw_r = 16'sd16384; drv_tw_i = 16'sd0;
        send(16'sd1234, -16'sd567, 1'b0);
        in_valid = 1'b0;
        chk("latency_n1", out_valid, 0);
        step();
        chk("latency_n2", out_valid, 0);
        step();
        chk("latency_n3", out_valid, 1);
        repeat (3) step();

        // Reset with three samples in flight.
        gen_mode = 1'b1;
        for (int k = 0; k < 3; k++) send(rdat(), rdat(), 1'b0);
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        #1;
        chk("in_ready_during_rst", in_ready, 0);
        step();
        chk("out_valid_after_rst", out_valid, 0);
        rst = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("quiet_after_rst", out_valid, 0);
        end

        // Eight back-to-back twiddled samples from a fresh counter: last on 4th and 8th.
        pc0 = pop_cnt;
        for (int k = 0; k < 8; k++) send(rdat(), rdat(), 1'b0);
        in_valid = 1'b0;
        repeat (6) step();
        chk("stream_pop_count", pop_cnt - pc0, 8);

        // Alternating bypass: twiddle order must stay 0,1,2,3.
        pc0 = pop_cnt;
        for (int k = 0; k < 8; k++) send(rdat(), rdat(), (k % 2) == 0);
        in_valid = 1'b0;
        repeat (6) step();
        chk("bypass_pop_count", pop_cnt - pc0, 4);

        // Backpressure: pipeline absorbs three samples, then stalls.
        out_ready = 1'b0;
        in_valid = 1'b1; in_bypass = 1'b0; in_r = rdat(); in_i = rdat();
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("bp_in_ready", in_ready, c < 3);
            took = in_ready;
            step();
            if (took) begin
                in_r = rdat(); in_i = rdat(); in_bypass = ($urandom % 2) == 0;
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (6) step();
        chk("bp_drain_empty", exp_q.size(), 0);

        rand_phase(300);
        gen_mode = 1'b0;
        rand_phase(300);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        n_vec++;
        n_err++;
        $display("FAIL watchdog: bench still running at t=%0t, expected completion earlier", $time);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
